// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and default protocol bytes for the boot loader
package boot_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RESP, RUN} state_t;
  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;
endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: packs little-endian payload bytes into words and keeps the frame XOR
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        xor_en,
  input  logic        data_en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done,
  output logic [7:0]  csum
);
  logic [1:0] idx;
  logic [23:0] sh;
  assign word = {din, sh};
  assign word_done = data_en & (idx == 2'd3);
  // byte index, last three payload bytes and running XOR; cleared at each frame start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      sh <= '0;
      csum <= '0;
    end else if (clr) begin
      idx <= '0;
      csum <= '0;
    end else begin
      if (xor_en) csum <= csum ^ din;
      if (data_en) begin
        idx <= idx + 2'd1;
        sh <= {din, sh[23:8]};
      end
    end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed image over UART, writes it to imem, acks and releases the core
module uart_boot_loader import boot_pkg::*; #(
  parameter logic [7:0]  MAGIC = MAGIC_DEF,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] BOOT_BASE = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE = ACK_DEF,
  parameter logic [7:0]  NAK_BYTE = NAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        core_rstn,
  output logic        loader_busy,
  output logic        err_checksum,
  output logic        err_length,
  output logic        err_timeout
);
  state_t state, nxt;
  logic acc, counting, timeout, clr, done, ack, nak, e_len, e_cs;
  logic [7:0] csum, len_lo;
  logic [15:0] len, widx, n;
  logic [31:0] word, cnt;
  assign s_axis_tready = state != RESP;
  assign acc = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = state == RESP;
  assign loader_busy = state inside {LEN0, LEN1, DATA, CSUM, RESP};
  assign counting = state inside {LEN0, LEN1, DATA, CSUM};
  assign timeout = counting & ~acc & (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign n = {s_axis_tdata, len_lo};
  assign clr = acc & (s_axis_tdata == MAGIC) & (state == IDLE || state == RUN);
  boot_word_assembler u_asm (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .xor_en(acc & (state inside {LEN0, LEN1, DATA})),
    .data_en(acc & (state == DATA)),
    .din(s_axis_tdata),
    .word(word),
    .word_done(done),
    .csum(csum)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state and response selection; a timeout overrides whatever the frame was doing
  always_comb begin
    nxt = state;
    ack = 1'b0;
    nak = 1'b0;
    e_len = 1'b0;
    e_cs = 1'b0;
    case (state)
      IDLE, RUN: if (clr) nxt = LEN0;
      LEN0: if (acc) nxt = LEN1;
      LEN1: if (acc) begin
        e_len = n > 16'(IMEM_WORDS);
        nak = e_len;
        nxt = e_len ? RESP : (n == 16'd0 ? CSUM : DATA);
      end
      DATA: if (done && widx == len - 16'd1) nxt = CSUM;
      CSUM: if (acc) begin
        ack = s_axis_tdata == csum;
        e_cs = ~ack;
        nak = ~ack;
        nxt = RESP;
      end
      RESP: if (m_axis_tready) nxt = m_axis_tdata == ACK_BYTE ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
    if (timeout) begin
      nak = 1'b1;
      nxt = RESP;
    end
  end
  // length/word counters, idle timer, memory write port, response byte, core reset and error flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      len_lo <= '0;
      len <= '0;
      widx <= '0;
      imem_wr_en <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      m_axis_tdata <= '0;
      core_rstn <= 1'b0;
      err_checksum <= 1'b0;
      err_length <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= (acc || !counting) ? '0 : cnt + 32'd1;
      if (state == LEN0 && acc) len_lo <= s_axis_tdata;
      if (state == LEN1 && acc) begin
        len <= n;
        widx <= '0;
      end else if (done) widx <= widx + 16'd1;
      imem_wr_en <= done;
      if (done) begin
        imem_wr_addr <= BOOT_BASE + {14'd0, widx, 2'b00};
        imem_wr_data <= word;
      end
      if (ack || nak) m_axis_tdata <= ack ? ACK_BYTE : NAK_BYTE;
      core_rstn <= nxt == RUN;
      err_checksum <= ~clr & (err_checksum | e_cs);
      err_length <= ~clr & (err_length | e_len);
      err_timeout <= ~clr & (err_timeout | timeout);
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: randomized frames against a frame-level model with write/response scoreboards
module tb_uart_boot_loader;
  localparam int TO = 300;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  logic clk = 0, rst = 1;
  logic [7:0] s_axis_tdata = 0, m_axis_tdata;
  logic s_axis_tvalid = 0, s_axis_tready, m_axis_tvalid, m_axis_tready = 0;
  logic imem_wr_en, core_rstn, loader_busy, err_checksum, err_length, err_timeout;
  logic [31:0] imem_wr_addr, imem_wr_data;
  int n_vec = 0, n_err = 0;
  logic [63:0] exp_wr[$];
  logic [7:0] exp_resp[$];
  logic [31:0] wbuf[$];
  logic [63:0] ew;
  logic [7:0] er;
  bit hold = 0, exp_run = 0, x_cs = 0, x_len = 0, x_to = 0;

  uart_boot_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .core_rstn(core_rstn), .loader_busy(loader_busy),
    .err_checksum(err_checksum), .err_length(err_length), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // random TX backpressure, frozen low while hold is set
  initial forever begin
    @(posedge clk);
    #1 m_axis_tready = !hold && ($urandom_range(0, 3) != 0);
  end

  // write monitor
  always @(negedge clk)
    if (!rst && imem_wr_en) begin
      if (exp_wr.size() == 0) flag_fail($sformatf("unexpected_write addr %0h data %0h", imem_wr_addr, imem_wr_data));
      else begin
        ew = exp_wr.pop_front();
        chk("imem_write", {imem_wr_addr, imem_wr_data}, ew);
      end
    end

  // response monitor; the core release is checked on the cycle after each handshake
  always @(negedge clk)
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_resp.size() == 0) flag_fail($sformatf("unexpected_resp %0h", m_axis_tdata));
      else begin
        er = exp_resp.pop_front();
        chk("resp_byte", m_axis_tdata, er);
        @(negedge clk);
        chk("core_rstn_after_resp", core_rstn, er == ACK);
        chk("tvalid_drop", m_axis_tvalid, 0);
      end
    end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    s_axis_tdata = b;
    s_axis_tvalid = 1;
    for (k = 0; k < 2000 && !s_axis_tready; k++) @(negedge clk);
    if (!s_axis_tready) flag_fail("send_byte_stuck");
    @(posedge clk);
    #1 s_axis_tvalid = 0;
  endtask

  task automatic fill(input int n);
    wbuf.delete();
    repeat (n) wbuf.push_back($urandom);
  endtask

  task automatic run_frame(input int nf, input bit bad, input int stop, input bit stall);
    logic [7:0] fb[$];
    logic [7:0] cs, r, d;
    logic [31:0] w;
    int p, k;
    fb.push_back(8'hA5);
    fb.push_back(nf[7:0]);
    fb.push_back(nf[15:8]);
    cs = nf[7:0] ^ nf[15:8];
    x_cs = 0; x_len = 0; x_to = 0;
    if (nf > 1024) begin
      r = NAK;
      x_len = 1;
    end else begin
      p = 0;
      for (int i = 0; i < nf; i++) begin
        w = wbuf[i];
        for (int j = 0; j < 4; j++)
          if (stop < 0 || p < stop) begin
            fb.push_back(w[8*j+:8]);
            cs ^= w[8*j+:8];
            p++;
          end
        if (stop < 0 || (i + 1) * 4 <= stop) exp_wr.push_back({32'(i * 4), w});
      end
      if (stop >= 0) begin
        r = NAK;
        x_to = 1;
      end else begin
        fb.push_back(bad ? cs ^ 8'h01 : cs);
        r = bad ? NAK : ACK;
        x_cs = bad;
      end
    end
    exp_resp.push_back(r);
    foreach (fb[i]) begin
      send_byte(fb[i]);
      if (i == 0) chk("core_rstn_drop_on_magic", core_rstn, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (stall) begin
      for (k = 0; k < 100 && !m_axis_tvalid; k++) @(negedge clk);
      d = m_axis_tdata;
      chk("stall_resp_byte", d, r);
      repeat (20) begin
        @(negedge clk);
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, d);
        chk("stall_s_tready", s_axis_tready, 0);
      end
      hold = 0;
    end
    exp_run = r == ACK;
    for (k = 0; k < TO + 500 && (exp_wr.size() != 0 || exp_resp.size() != 0); k++) @(negedge clk);
    if (exp_wr.size() != 0 || exp_resp.size() != 0) begin
      flag_fail($sformatf("frame_incomplete writes_left %0d resps_left %0d", exp_wr.size(), exp_resp.size()));
      exp_wr.delete();
      exp_resp.delete();
    end
    repeat (2) @(negedge clk);
    chk("loader_busy_idle", loader_busy, 0);
    chk("core_rstn", core_rstn, exp_run);
    chk("err_flags", {err_checksum, err_length, err_timeout}, {x_cs, x_len, x_to});
    chk("s_tready_idle", s_axis_tready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_core_rstn"}, core_rstn, 0);
    chk({tag, "_busy"}, loader_busy, 0);
    chk({tag, "_wr"}, {imem_wr_en, imem_wr_addr, imem_wr_data}, 0);
    chk({tag, "_m_axis"}, {m_axis_tvalid, m_axis_tdata}, 0);
    chk({tag, "_errs"}, {err_checksum, err_length, err_timeout}, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 1);
  endtask

  initial begin
    int nf, kind;
    logic [7:0] junk;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 0;
    repeat (2) @(negedge clk);
    wbuf.delete();
    wbuf.push_back(32'h00500093);
    run_frame(1, 0, -1, 0);
    run_frame(1, 1, -1, 0);
    run_frame(1025, 0, -1, 0);
    fill(2);
    run_frame(2, 0, 4, 0);
    hold = 1;
    run_frame(0, 0, -1, 1);
    send_byte(8'h00);
    @(negedge clk);
    chk("run_ignores_junk", core_rstn, 1);
    run_frame(0, 0, -1, 0);
    repeat (15) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk);
      end
      nf = $urandom_range(0, 6);
      fill(nf);
      if (kind == 0) run_frame($urandom_range(1025, 65535), 0, -1, 0);
      else if (kind == 1 && nf > 0) run_frame(nf, 0, $urandom_range(0, nf * 4 - 1), 0);
      else run_frame(nf, $urandom_range(0, 3) == 0, -1, 0);
    end
    fill(1024);
    run_frame(1024, 0, -1, 0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    #2 rst = 1;
    #1 check_reset_values("async_reset");
    exp_run = 0;
    @(negedge clk);
    rst = 0;
    fill(3);
    run_frame(3, 0, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
